// File: rtl/turn_controller.sv
// turn_controller: per-turn countdown, scoring and winner logic for the card-matching game.
// Every output is a flop; the comb blocks compute next-state and next-register values.
module turn_controller #(
    parameter int CLK_PER_SEC = 50000000,
    parameter int TURN_SECS   = 15,
    parameter int NUM_PAIRS   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pair_valid,
    input  logic       pair_match,
    input  logic       pause,
    output logic [3:0] timer,
    output logic       cur_player,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       turn_start
);
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [3:0] TS = 4'(TURN_SECS);
    localparam logic [3:0] NP = 4'(NUM_PAIRS);
    localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, PLAY, SWITCH, OVER} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    pairs, pairs_nxt, timer_nxt, sp1_nxt, sp2_nxt;
    logic [1:0]    winner_nxt;
    logic          player_nxt, over_nxt, ts_nxt;
    logic          tick, hit, miss, begin_game;

    assign tick       = state == PLAY && !pause && presc == PMAX;
    assign hit        = state == PLAY && pair_valid && pair_match;
    assign miss       = state == PLAY && pair_valid && !pair_match;
    assign begin_game = (state == IDLE || state == OVER) && start;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc      <= '0;
            timer      <= TS;
            cur_player <= 1'b0;
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            pairs      <= 4'd0;
            winner     <= 2'b00;
            game_over  <= 1'b0;
            turn_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            timer      <= timer_nxt;
            cur_player <= player_nxt;
            score_p1   <= sp1_nxt;
            score_p2   <= sp2_nxt;
            pairs      <= pairs_nxt;
            winner     <= winner_nxt;
            game_over  <= over_nxt;
            turn_start <= ts_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? PLAY : IDLE;
            PLAY:    state_nxt = hit ? (pairs + 4'd1 == NP ? OVER : PLAY)
                               : (miss || (tick && timer <= 4'd1)) ? SWITCH : PLAY;
            SWITCH:  state_nxt = PLAY;
            default: state_nxt = start ? PLAY : OVER;
        endcase
    end

    always_comb begin
        presc_nxt  = presc;
        timer_nxt  = timer;
        player_nxt = cur_player;
        sp1_nxt    = score_p1;
        sp2_nxt    = score_p2;
        pairs_nxt  = pairs;
        if (begin_game) begin
            presc_nxt  = '0;
            timer_nxt  = TS;
            player_nxt = 1'b0;
            sp1_nxt    = 4'd0;
            sp2_nxt    = 4'd0;
            pairs_nxt  = 4'd0;
        end else if (state == SWITCH) begin
            presc_nxt  = '0;
            timer_nxt  = TS;
            player_nxt = !cur_player;
        end else if (hit) begin
            presc_nxt = '0;
            timer_nxt = TS;
            pairs_nxt = pairs + 4'd1;
            sp1_nxt   = (!cur_player && score_p1 != 4'hf) ? score_p1 + 4'd1 : score_p1;
            sp2_nxt   = (cur_player && score_p2 != 4'hf) ? score_p2 + 4'd1 : score_p2;
        end else if (state == PLAY && !pause && !pair_valid) begin
            // a pair event in the same cycle swallows the tick
            presc_nxt = tick ? '0 : presc + PW'(1);
            timer_nxt = tick ? timer - 4'd1 : timer;
        end
        winner_nxt = begin_game ? 2'b00
                   : (state_nxt == OVER && state != OVER)
                     ? (sp1_nxt > sp2_nxt ? 2'b01 : sp1_nxt < sp2_nxt ? 2'b10 : 2'b11)
                   : winner;
        over_nxt   = state_nxt == OVER;
        ts_nxt     = begin_game || state == SWITCH;
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed checks of turn_controller with a 4-cycle second and 3-second turns.
module tb_turn_controller;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       pair_valid = 1'b0;
    logic       pair_match = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] timer;
    logic       cur_player;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       game_over;
    logic       turn_start;
    int         n_cmp = 0;
    int         n_bad = 0;

    turn_controller #(.CLK_PER_SEC(4), .TURN_SECS(3), .NUM_PAIRS(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .pair_valid(pair_valid),
        .pair_match(pair_match), .pause(pause), .timer(timer), .cur_player(cur_player),
        .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .game_over(game_over),
        .turn_start(turn_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // one-cycle pair event from the current player
    task automatic pair(input logic m);
        pair_valid = 1'b1;
        pair_match = m;
        step();
        pair_valid = 1'b0;
        pair_match = 1'b0;
    endtask

    // reset, then start; afterwards the DUT is in PLAY with a fresh prescaler
    task automatic new_game();
        pause = 1'b0;
        pair_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        step(2);
        reset_n = 1'b1;
        step(20);
        check("idle_timer", timer, 3);
        check("idle_player", cur_player, 0);
        check("idle_p1", score_p1, 0);
        check("idle_p2", score_p2, 0);
        check("idle_winner", winner, 0);
        check("idle_over", game_over, 0);
        check("idle_ts", turn_start, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ts", turn_start, 1);
        check("start_timer", timer, 3);
        step(3);
        check("pre_tick_timer", timer, 3);
        check("ts_one_cycle", turn_start, 0);
        step();
        check("tick1_timer", timer, 2);
        step(4);
        check("tick2_timer", timer, 1);
        step(4);
        check("timeout_timer", timer, 0);
        check("timeout_player", cur_player, 0);
        step();
        check("switch_timer", timer, 3);
        check("switch_player", cur_player, 1);
        check("switch_ts", turn_start, 1);
        step();
        check("switch_ts_low", turn_start, 0);

        new_game();
        step(5);
        check("mid_timer", timer, 2);
        pair(1'b1);
        check("match_p1", score_p1, 1);
        check("match_reload", timer, 3);
        check("match_player", cur_player, 0);
        check("match_not_over", game_over, 0);
        pair(1'b0);
        step();
        check("miss_player", cur_player, 1);
        check("miss_ts", turn_start, 1);
        check("miss_p1", score_p1, 1);
        check("miss_p2", score_p2, 0);

        new_game();
        step(2);
        pause = 1'b1;
        step(10);
        check("pause_timer", timer, 3);
        pause = 1'b0;
        step();
        check("resume_timer_a", timer, 3);
        step();
        check("resume_timer_b", timer, 2);
        pause = 1'b1;
        pair(1'b1);
        check("pause_pair_p1", score_p1, 1);
        check("pause_pair_timer", timer, 3);
        pause = 1'b0;

        new_game();
        step(11);
        check("edge_timer", timer, 1);
        pair(1'b1);
        check("edge_reload", timer, 3);
        check("edge_p1", score_p1, 1);
        step();
        check("edge_player", cur_player, 0);
        check("edge_no_ts", turn_start, 0);
        check("edge_timer_hold", timer, 3);

        new_game();
        step();
        pair(1'b1);
        pair(1'b0);
        step();
        check("tie_p2_turn", cur_player, 1);
        pair(1'b1);
        check("tie_over", game_over, 1);
        check("tie_winner", winner, 3);
        check("tie_p2", score_p2, 1);
        pair(1'b1);
        check("over_ignore_pair", score_p2, 1);
        step(6);
        check("over_timer_hold", timer, 3);
        check("over_hold", game_over, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_p1", score_p1, 0);
        check("restart_p2", score_p2, 0);
        check("restart_winner", winner, 0);
        check("restart_over", game_over, 0);
        check("restart_player", cur_player, 0);
        check("restart_ts", turn_start, 1);

        new_game();
        pair(1'b1);
        pair(1'b1);
        check("p1win_over", game_over, 1);
        check("p1win_winner", winner, 1);
        check("p1win_score", score_p1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
